lc3_mem_arbiter: RTL and testbench
==================================

// Module: lc3_mem_arbiter
// PURPOSE
// - Shares one single-port LC-3 memory between two requesters: port 0 = CPU datapath, port 1 = DMA/loader.
// - Sequences each access: grant, hold the address and data, count memory wait states, return read data, pulse ready.
// - Sits between the lc3 core's memory port (memEN/memWE/memRDY protocol) and the memory array.
// PARAMETERS
// - WAIT_CYCLES  2  extra memory wait states per access, range 0..15
// - CNT_W        4  wait counter width; must satisfy 2**CNT_W > WAIT_CYCLES
// PORTS
// - clk        in   1   system clock, all state on rising edge
// - rst        in   1   reset, asynchronous, active-low
// - cpu_en     in   1   CPU request, held high until cpu_rdy
// - cpu_we     in   1   CPU write (1) / read (0)
// - cpu_addr   in   16  CPU address
// - cpu_din    in   16  CPU write data
// - cpu_dout   out  16  CPU read data, valid while cpu_rdy=1
// - cpu_rdy    out  1   one-cycle CPU completion pulse
// - dma_en/dma_we/dma_addr/dma_din/dma_dout/dma_rdy  same as the CPU signals, for port 1
// - mem_en     out  1   memory enable
// - mem_we     out  1   memory write enable
// - mem_addr   out  16  memory address
// - mem_din    out  16  memory write data
// - mem_dout   in   16  memory read data, sampled on the last ACCESS cycle
// - busy       out  1   high in every state except IDLE
// - grant_dma  out  1   owner of the current or last access (0 = CPU, 1 = DMA)
// BEHAVIOUR
// - FSM states: IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE, any en high:
//   - pick the winner; register its we/addr/din into mem_we/mem_addr/mem_din; set mem_en=1.
//   - load cnt=WAIT_CYCLES; set grant_dma; go to ACCESS.
// - ACCESS:
//   - mem_en/we/addr/din stay stable.
//   - cnt>0: decrement.
//   - cnt==0: register mem_dout into the winner's dout (reads only); clear mem_en and mem_we; go to DONE.
// - DONE: the winner's rdy=1 for exactly one cycle, then go to IDLE.
//   - The loser's rdy stays 0 and its dout is unchanged.
// - Latency: request visible in IDLE -> rdy high WAIT_CYCLES+2 cycles later. mem_en is high for WAIT_CYCLES+1 cycles.
// - Protocol:
//   - The requester drops en on the edge where it samples rdy=1.
//   - en still high in the following IDLE cycle counts as a new request (back-to-back allowed).
//   - en dropped during ACCESS does not abort; the access completes and rdy still pulses.
//   - A request held in IDLE is granted that same cycle; the minimum gap between accesses is the one IDLE cycle.
// - Simultaneous requests in IDLE: arbitration policy (see CONFIGURATION). The loser waits; its inputs are not latched.
// - Write: the memory array commits mem_din on the last ACCESS cycle. dout is not updated on writes.
// - Counter: unsigned CNT_W bits, never underflows (DONE is taken at 0). WAIT_CYCLES=0 gives a single ACCESS cycle.
// - Reset (rst=0, any time, including mid-access):
//   - state=IDLE; mem_en=mem_we=0; mem_addr=mem_din=0.
//   - cpu_dout=dma_dout=0; cpu_rdy=dma_rdy=0; busy=0; grant_dma=0; cnt=0; RR pointer=DMA-last.
//   - The interrupted access is dropped with no rdy. The memory may have taken a partial write.
// CONFIGURATION
// - Macro LC3_ARB_ROUND_ROBIN_EN.
// - Defined: round-robin arbitration.
//   - On a simultaneous request, the port not granted last wins.
//   - The last-granted pointer updates at grant and resets to DMA-last, so CPU wins the first tie.
// - Undefined: fixed priority, CPU always wins a tie. DMA can starve under continuous CPU traffic (accepted).
// - A single requester is granted immediately in both modes.
// TESTING
// - Reset, then CPU read at addr 0x3000 with mem_dout=0xBEEF, WAIT_CYCLES=2 -> mem_en high 3 cycles, cpu_rdy pulses once 4 cycles after request, cpu_dout=0xBEEF, dma_rdy=0.
// - DMA write of addr 0x0200 data 0x1234 -> mem_we=1 with mem_addr=0x0200, mem_din=0x1234 throughout ACCESS; dma_rdy pulses; dma_dout unchanged.
// - cpu_en and dma_en both held high for 4 accesses -> fixed priority: grants C,C,C,C; round-robin: C,D,C,D.
// - rst low on the 2nd ACCESS cycle -> all outputs 0 asynchronously, no rdy; after release a new CPU request completes normally.
// - WAIT_CYCLES=0, CPU holds en after rdy -> accesses repeat every 3 cycles (IDLE, ACCESS, DONE), one rdy each.
// - CPU drops cpu_en during ACCESS -> access completes, cpu_rdy still pulses once, then IDLE with busy=0.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Two-port (CPU / DMA) arbiter and access sequencer for a single-port LC-3 memory.
// Optional macro LC3_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: CPU priority).
module lc3_mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_rdy,
  input  logic        dma_en,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic [15:0] dma_dout,
  output logic        dma_rdy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        busy,
  output logic        grant_dma
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             anyReq;
  logic             pickDma;
  logic             lastCycle;

  assign anyReq    = cpu_en | dma_en;
  assign lastCycle = (state == ACCESS) && (cnt == '0);
  assign busy      = (state != IDLE);

`ifdef LC3_ARB_ROUND_ROBIN_EN
  // Port granted most recently; resets to DMA so the CPU wins the first tie.
  logic lastDma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          lastDma <= 1'b1;
    else if (state == IDLE && anyReq)  lastDma <= pickDma;
  end

  assign pickDma = dma_en && (!cpu_en || !lastDma);
`else
  assign pickDma = dma_en && !cpu_en;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (cnt == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: the loser's inputs are never latched, so a held request is
  // simply re-evaluated in the next IDLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_dout  <= '0;
      dma_dout  <= '0;
      cpu_rdy   <= 1'b0;
      dma_rdy   <= 1'b0;
      grant_dma <= 1'b0;
      cnt       <= '0;
    end else begin
      cpu_rdy <= 1'b0;
      dma_rdy <= 1'b0;
      if (state == IDLE && anyReq) begin
        grant_dma <= pickDma;
        mem_en    <= 1'b1;
        mem_we    <= pickDma ? dma_we   : cpu_we;
        mem_addr  <= pickDma ? dma_addr : cpu_addr;
        mem_din   <= pickDma ? dma_din  : cpu_din;
        cnt       <= CNT_W'(WAIT_CYCLES);
      end else if (state == ACCESS && !lastCycle) begin
        cnt <= cnt - 1'b1;
      end else if (lastCycle) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (!mem_we) begin
          if (grant_dma) dma_dout <= mem_dout;
          else           cpu_dout <= mem_dout;
        end
        if (grant_dma) dma_rdy <= 1'b1;
        else           cpu_rdy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level memory/arbitration model.
module tb_lc3_mem_arbiter;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpuEn, cpuWe, dmaEn, dmaWe;
  logic [15:0] cpuAddr, cpuDin, dmaAddr, dmaDin;
  logic [15:0] cpuDout, dmaDout, memAddr, memDin, memDout;
  logic        cpuRdy, dmaRdy, memEn, memWe, busy, grantDma;

  logic        cpuEn0, cpuWe0, dmaEn0, dmaWe0;
  logic [15:0] cpuAddr0, cpuDin0, dmaAddr0, dmaDin0;
  logic [15:0] cpuDout0, dmaDout0, memAddr0, memDin0, memDout0;
  logic        cpuRdy0, dmaRdy0, memEn0, memWe0, busy0, grantDma0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.WAIT_CYCLES(WAIT), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpuEn), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_din(cpuDin),
    .cpu_dout(cpuDout), .cpu_rdy(cpuRdy),
    .dma_en(dmaEn), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_din(dmaDin),
    .dma_dout(dmaDout), .dma_rdy(dmaRdy),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_din(memDin),
    .mem_dout(memDout), .busy(busy), .grant_dma(grantDma));

  lc3_mem_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_en(cpuEn0), .cpu_we(cpuWe0), .cpu_addr(cpuAddr0), .cpu_din(cpuDin0),
    .cpu_dout(cpuDout0), .cpu_rdy(cpuRdy0),
    .dma_en(dmaEn0), .dma_we(dmaWe0), .dma_addr(dmaAddr0), .dma_din(dmaDin0),
    .dma_dout(dmaDout0), .dma_rdy(dmaRdy0),
    .mem_en(memEn0), .mem_we(memWe0), .mem_addr(memAddr0), .mem_din(memDin0),
    .mem_dout(memDout0), .busy(busy0), .grant_dma(grantDma0));

  // Memory array: unwritten words read back a fixed pattern.
  function automatic logic [15:0] initVal(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  logic [15:0] memArr   [0:65535];
  bit          memValid [0:65535];
  assign memDout  = memValid[memAddr] ? memArr[memAddr] : initVal(memAddr);
  assign memDout0 = memAddr0 ^ 16'h5A5A;

  always @(posedge clk) begin
    if (memEn && memWe) begin
      memArr[memAddr]   <= memDin;
      memValid[memAddr] <= 1'b1;
    end
  end

  // Reference model state
  logic [15:0] refMem [int];
  logic [15:0] refCpuDout, refDmaDout;
  bit          refLastDma;

  function automatic logic [15:0] refRead(input logic [15:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : initVal(a);
  endfunction

  function automatic bit tieWinnerDma();
`ifdef LC3_ARB_ROUND_ROBIN_EN
    return !refLastDma;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if ({memEn, memWe, memAddr, memDin, cpuDout, cpuRdy, dmaDout, dmaRdy, busy, grantDma} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {memEn, memWe, memAddr, memDin, cpuDout, cpuRdy, dmaDout, dmaRdy, busy, grantDma});
    end
    total++;
    if ({memEn0, busy0, cpuRdy0, cpuDout0} !== '0) begin
      bad++; $display("FAIL reset_outputs_w0 got=%h want=0", {memEn0, busy0, cpuRdy0, cpuDout0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b want=0", busy); end
    refLastDma = 1'b1; refCpuDout = '0; refDmaDout = '0;
  endtask

  task automatic test_cpu_read();
    int rdyCyc = 0, enCnt = 0, rdyCnt = 0;
    bit dmaSeen = 0, addrBad = 0;
    logic [15:0] gotDout = '0;
    @(negedge clk);
    cpuWe = 1'b0; cpuAddr = 16'h3000; cpuEn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (memEn) begin enCnt++; if (memAddr !== 16'h3000 || memWe !== 1'b0) addrBad = 1; end
      if (dmaRdy) dmaSeen = 1;
      if (cpuRdy) begin
        rdyCnt++;
        if (rdyCyc == 0) begin rdyCyc = i; gotDout = cpuDout; end
        cpuEn = 1'b0;
      end
    end
    total++; if (rdyCyc != WAIT + 2) begin bad++; $display("FAIL cpu_read_latency got=%0d want=%0d", rdyCyc, WAIT + 2); end
    total++; if (enCnt != WAIT + 1) begin bad++; $display("FAIL cpu_read_memen_cycles got=%0d want=%0d", enCnt, WAIT + 1); end
    total++; if (rdyCnt != 1) begin bad++; $display("FAIL cpu_read_rdy_count got=%0d want=1", rdyCnt); end
    total++; if (gotDout !== 16'hBEEF) begin bad++; $display("FAIL cpu_read_dout got=%h want=beef", gotDout); end
    total++; if (dmaSeen || addrBad) begin bad++; $display("FAIL cpu_read_side dmaRdy=%b addrBad=%b want=0/0", dmaSeen, addrBad); end
    refCpuDout = 16'hBEEF; refLastDma = 1'b0;
  endtask

  task automatic test_dma_write();
    int rdyCyc = 0, enCnt = 0;
    bit cpuSeen = 0, busBad = 0;
    logic [15:0] gotDout = '0;
    logic gotGrant = 1'b0;
    @(negedge clk);
    dmaWe = 1'b1; dmaAddr = 16'h0200; dmaDin = 16'h1234; dmaEn = 1'b1;
    for (int i = 1; i <= 12 && rdyCyc == 0; i++) begin
      @(posedge clk); @(negedge clk);
      if (memEn) begin
        enCnt++;
        if (memWe !== 1'b1 || memAddr !== 16'h0200 || memDin !== 16'h1234) busBad = 1;
      end
      if (cpuRdy) cpuSeen = 1;
      if (dmaRdy) begin rdyCyc = i; gotDout = dmaDout; gotGrant = grantDma; dmaEn = 1'b0; end
    end
    total++; if (rdyCyc != WAIT + 2) begin bad++; $display("FAIL dma_write_latency got=%0d want=%0d", rdyCyc, WAIT + 2); end
    total++; if (busBad || enCnt != WAIT + 1) begin bad++; $display("FAIL dma_write_bus busBad=%b enCnt=%0d want=0/%0d", busBad, enCnt, WAIT + 1); end
    total++; if (gotDout !== refDmaDout) begin bad++; $display("FAIL dma_write_dout_kept got=%h want=%h", gotDout, refDmaDout); end
    total++; if (gotGrant !== 1'b1 || cpuSeen) begin bad++; $display("FAIL dma_write_grant grant=%b cpuRdy=%b want=1/0", gotGrant, cpuSeen); end
    total++; if (memArr[16'h0200] !== 16'h1234) begin bad++; $display("FAIL dma_write_commit got=%h want=1234", memArr[16'h0200]); end
    refMem[16'h0200] = 16'h1234; refLastDma = 1'b1;
  endtask

  task automatic test_arbitration();
    int order [4];
    int n = 0;
    bit both = 0;
    // Each port is always requesting, so every grant is a tie.
    @(negedge clk);
    cpuWe = 1'b0; cpuAddr = 16'h4100; dmaWe = 1'b0; dmaAddr = 16'h4200;
    cpuEn = 1'b1; dmaEn = 1'b1;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (cpuRdy && dmaRdy) both = 1;
      else if (cpuRdy) order[n++] = 0;
      else if (dmaRdy) order[n++] = 1;
    end
    cpuEn = 1'b0; dmaEn = 1'b0;
    total++; if (n != 4 || both) begin bad++; $display("FAIL arb_completions got=%0d both=%b want=4/0", n, both); end
    for (int k = 0; k < 4; k++) begin
      bit expDma;
      expDma = tieWinnerDma();
      total++;
      if (order[k] != int'(expDma)) begin bad++; $display("FAIL arb_grant_%0d got=%0d want=%0d", k, order[k], expDma); end
      refLastDma = expDma;
      if (expDma) refDmaDout = refRead(16'h4200); else refCpuDout = refRead(16'h4100);
    end
    total++; if (cpuDout !== refCpuDout || dmaDout !== refDmaDout) begin
      bad++; $display("FAIL arb_dout cpu=%h/%h dma=%h/%h (got/want)", cpuDout, refCpuDout, dmaDout, refDmaDout);
    end
  endtask

  task automatic test_reset_mid();
    bit rdySeen = 0;
    int rdyCyc = 0;
    @(negedge clk);
    cpuWe = 1'b0; cpuAddr = 16'h4300; cpuEn = 1'b1;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({memEn, memWe, memAddr, memDin, cpuDout, cpuRdy, dmaDout, dmaRdy, busy, grantDma} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0",
        {memEn, memWe, memAddr, memDin, cpuDout, cpuRdy, dmaDout, dmaRdy, busy, grantDma});
    end
    cpuEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpuRdy || dmaRdy || busy) rdySeen = 1;
    end
    rst = 1'b1;
    refLastDma = 1'b1; refCpuDout = '0; refDmaDout = '0;
    @(negedge clk);
    total++; if (rdySeen) begin bad++; $display("FAIL midreset_no_rdy got=1 want=0"); end
    cpuAddr = 16'h4400; cpuEn = 1'b1;
    for (int i = 1; i <= 12 && rdyCyc == 0; i++) begin
      @(posedge clk); @(negedge clk);
      if (cpuRdy) begin rdyCyc = i; cpuEn = 1'b0; end
    end
    total++; if (rdyCyc != WAIT + 2 || cpuDout !== refRead(16'h4400)) begin
      bad++; $display("FAIL midreset_recover lat=%0d dout=%h want=%0d/%h", rdyCyc, cpuDout, WAIT + 2, refRead(16'h4400));
    end
    refCpuDout = refRead(16'h4400); refLastDma = 1'b0;
  endtask

  task automatic test_wait0();
    int rdyCnt = 0, enCnt = 0, lastRdy = 0;
    bit gapBad = 0, doutBad = 0;
    @(negedge clk);
    cpuWe0 = 1'b0; cpuAddr0 = 16'h1357; cpuEn0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (memEn0) enCnt++;
      if (cpuRdy0) begin
        rdyCnt++;
        if (i - lastRdy != ((lastRdy == 0) ? 2 : 3)) gapBad = 1;
        if (cpuDout0 !== (16'h1357 ^ 16'h5A5A)) doutBad = 1;
        lastRdy = i;
      end
    end
    cpuEn0 = 1'b0;
    total++; if (rdyCnt != 4 || gapBad) begin bad++; $display("FAIL wait0_rdy count=%0d gapBad=%b want=4/0", rdyCnt, gapBad); end
    total++; if (enCnt != 4) begin bad++; $display("FAIL wait0_memen got=%0d want=4", enCnt); end
    total++; if (doutBad) begin bad++; $display("FAIL wait0_dout got=%h want=%h", cpuDout0, 16'h1357 ^ 16'h5A5A); end
  endtask

  task automatic test_drop_en();
    int rdyCnt = 0;
    logic [15:0] gotDout = '0;
    @(negedge clk);
    cpuWe = 1'b0; cpuAddr = 16'h4500; cpuEn = 1'b1;
    @(posedge clk); @(negedge clk);
    cpuEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (cpuRdy) begin rdyCnt++; gotDout = cpuDout; end
    end
    total++; if (rdyCnt != 1) begin bad++; $display("FAIL drop_en_rdy got=%0d want=1", rdyCnt); end
    total++; if (gotDout !== refRead(16'h4500)) begin bad++; $display("FAIL drop_en_dout got=%h want=%h", gotDout, refRead(16'h4500)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_en_idle busy=%b want=0", busy); end
    refCpuDout = refRead(16'h4500); refLastDma = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      int mask, pending, idx, firstLat;
      bit exp [2];
      bit cW, dW;
      logic [15:0] cA, cD, dA, dD;
      mask = $urandom_range(1, 3);
      cW = 1'($urandom_range(0, 1)); dW = 1'($urandom_range(0, 1));
      cA = 16'h6000 + 16'($urandom_range(0, 7)); dA = 16'h6000 + 16'($urandom_range(0, 7));
      cD = 16'($urandom); dD = 16'($urandom);
      if (mask == 3) begin exp[0] = tieWinnerDma(); exp[1] = !exp[0]; end
      else begin exp[0] = (mask == 2); exp[1] = 0; end
      @(negedge clk);
      cpuWe = cW; cpuAddr = cA; cpuDin = cD; dmaWe = dW; dmaAddr = dA; dmaDin = dD;
      cpuEn = mask[0]; dmaEn = mask[1];
      pending = mask; idx = 0; firstLat = 0;
      for (int i = 1; i <= 40 && pending != 0; i++) begin
        @(posedge clk); @(negedge clk);
        if (cpuRdy && dmaRdy) begin
          total++; bad++; $display("FAIL rnd_both_rdy round=%0d", r);
          pending = 0;
        end else if (cpuRdy || dmaRdy) begin
          bit isDma;
          isDma = dmaRdy;
          if (idx == 0) firstLat = i;
          total++;
          if (isDma != exp[idx] || ((isDma ? 2 : 1) & pending) == 0) begin
            bad++; $display("FAIL rnd_order round=%0d idx=%0d got=%0d want=%0d", r, idx, isDma, exp[idx]);
          end
          if (!isDma) begin
            if (cW) refMem[int'(cA)] = cD; else refCpuDout = refRead(cA);
            cpuEn = 1'b0; pending &= ~1;
          end else begin
            if (dW) refMem[int'(dA)] = dD; else refDmaDout = refRead(dA);
            dmaEn = 1'b0; pending &= ~2;
          end
          refLastDma = isDma;
          total++;
          if (cpuDout !== refCpuDout || dmaDout !== refDmaDout) begin
            bad++; $display("FAIL rnd_dout round=%0d cpu=%h/%h dma=%h/%h (got/want)", r, cpuDout, refCpuDout, dmaDout, refDmaDout);
          end
          idx++;
        end
      end
      total++;
      if (pending != 0 || firstLat != WAIT + 2) begin
        bad++; $display("FAIL rnd_latency round=%0d pending=%0d lat=%0d want=0/%0d", r, pending, firstLat, WAIT + 2);
      end
      cpuEn = 1'b0; dmaEn = 1'b0;
    end
  endtask

  initial begin
    cpuEn = 0; cpuWe = 0; cpuAddr = '0; cpuDin = '0;
    dmaEn = 0; dmaWe = 0; dmaAddr = '0; dmaDin = '0;
    cpuEn0 = 0; cpuWe0 = 0; cpuAddr0 = '0; cpuDin0 = '0;
    dmaEn0 = 0; dmaWe0 = 0; dmaAddr0 = '0; dmaDin0 = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_arbitration();
    test_reset_mid();
    test_wait0();
    test_drop_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
